ipv4_parser: RTL and testbench
==============================

// Module: ipv4_parser
// PURPOSE
//  Consumes the Ethernet payload stream from eth_parser and strips and validates the IPv4 header.
//  Forwards only the IP payload (length from Total Length; Ethernet padding discarded) to the UDP stage.
//  Exposes header metadata. No backpressure: accepts one byte per eth_byte_valid cycle.
// PARAMETERS
//  PROTOCOL      8'd17            required IPv4 Protocol field (UDP)
//  LOCAL_IP      32'hC0A8_010A    accepted destination address (192.168.1.10)
//  ACCEPT_BCAST  1'b1             also accept dst 255.255.255.255
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    async active-low reset
//  eth_data_in     in   8    byte_t payload byte from eth_parser
//  eth_byte_valid  in   1    eth_data_in valid this cycle
//  eth_eof         in   1    last byte of Ethernet frame
//  eth_err         in   1    upstream error; with eth_eof = CRC fail, eth_data_in is stale and ignored
//  ip_data_out     out  8    byte_t IP payload byte
//  ip_byte_valid   out  1    ip_data_out valid
//  ip_eof          out  1    end of datagram (single-cycle pulse)
//  ip_err          out  1    header reject or datagram abort (single-cycle pulse)
//  ip_src_addr     out  32   source IP; valid from header accept until next header
//  ip_payload_len  out  16   Total Length - IHL*4; same validity
// BEHAVIOUR
//  One clock, async active-low reset. All outputs are registered, so latency is 1 cycle from input to output.
//  Reset: all outputs 0, state HEADER, counters and accumulator 0.
//  Reset mid-frame discards the frame silently. The next byte is treated as header byte 0.
//  Defaults every cycle: ip_byte_valid, ip_eof and ip_err = 0.
//  States:
//   HEADER
//    - Count bytes with hdr_cnt (6b). Capture version/IHL, total length, protocol, src, dst.
//    - Accumulate 16-bit big-endian words into a 21-bit one's-complement sum; 30 words max, so no overflow.
//    - Byte 0: version!=4 or IHL<5 -> ip_err, go to DROP.
//    - Byte IHL*4-1: fold the sum twice (sum[15:0]+sum[20:16]), including this final word.
//    - At that byte, reject if any of: fold!=16'hFFFF; protocol!=PROTOCOL;
//      dst not LOCAL_IP (nor bcast when ACCEPT_BCAST); MF=1 or fragment offset!=0; total_len<IHL*4.
//    - On reject: ip_err pulse, go to DROP.
//    - On accept: load ip_src_addr and ip_payload_len, load pay_cnt=payload_len.
//      Go to PAYLOAD, or to PAD if payload_len==0.
//    - eth_eof or eth_err while in HEADER: ip_err (no ip_eof), stay in HEADER, clear counters.
//   PAYLOAD
//    - Each valid byte: ip_data_out=byte, ip_byte_valid=1, pay_cnt--.
//    - Last counted byte (pay_cnt==1) goes to PAD.
//    - Last payload byte arriving with eth_eof (no padding): ip_byte_valid and ip_eof in the same cycle; go to HEADER.
//    - eth_eof before pay_cnt is exhausted (truncated): ip_eof+ip_err; the byte is emitted unless eth_err.
//   PAD
//    - Discard bytes. eth_eof goes to HEADER with an ip_eof pulse (no ip_byte_valid).
//   DROP
//    - Discard until eth_eof or eth_err, then go to HEADER silently.
//    - ip_err was already reported at the reject point.
//  eth_err in PAYLOAD or PAD: ip_eof+ip_err, go to HEADER, no ip_byte_valid.
//  Header errors never emit ip_eof; once PAYLOAD is entered, every datagram ends with exactly one ip_eof.
//  Bytes with eth_byte_valid=0 are ignored; eth_eof/eth_err are only sampled with eth_byte_valid=1.
// STRUCTURE
//  eth_pkg additions:
//   - IPV4_MIN_HDR_LEN=20; IPV4_MAX_HDR_LEN=60
//   - field offsets (VER_IHL=0, TOTLEN=2, FLAGS=6, PROTO=9, SRC=12, DST=16)
//   - IP_PROTO_UDP=8'd17; ip_addr_t (logic [31:0])
//  Sub-module ip_csum_acc: clear/add-byte/odd-even pairing, 21-bit accumulator, fold, is_ok output.
//  Reused later by the UDP stage.
// TESTING
//  1 Valid UDP to 192.168.1.10: IHL=5, total_len=0x0020, correct checksum, no padding
//    -> 12 payload bytes in order, ip_eof with the 12th, ip_payload_len=12, ip_err never.
//  2 Same header, total_len=0x001C, padded to 46 bytes -> 8 bytes out, ip_eof alone at eth_eof cycle.
//  3 Checksum byte flipped -> single ip_err at header byte 19, no ip_byte_valid or ip_eof; next good frame passes.
//  4 IHL=6 with 4 option bytes, proto=6 (TCP) -> ip_err at byte 23; proto=17 -> payload starts at byte 24.
//  5 eth_err+eth_eof mid-payload after 5 bytes -> 5 valid bytes, then ip_eof+ip_err, no 6th byte.
//  6 Version nibble=6 -> ip_err at byte 0 and DROP; also rst_n pulsed mid-payload -> outputs 0, next frame clean.

Source files
------------

// File: rtl/ipv4_parser_pkg.sv
// Shared IPv4 types, header layout constants and the one's-complement fold helper.
package ipv4_parser_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] ip_addr_t;

   localparam int IPV4_MAX_HDR_LEN = 60;
   localparam int HDR_CNT_W        = $clog2(IPV4_MAX_HDR_LEN);

   localparam logic [HDR_CNT_W-1:0] IPV4_MIN_HDR_LEN = HDR_CNT_W'(20);

   // Byte offsets of the header fields the parser looks at
   localparam logic [HDR_CNT_W-1:0] OFF_VER_IHL = HDR_CNT_W'(0);
   localparam logic [HDR_CNT_W-1:0] OFF_TOTLEN  = HDR_CNT_W'(2);
   localparam logic [HDR_CNT_W-1:0] OFF_FLAGS   = HDR_CNT_W'(6);
   localparam logic [HDR_CNT_W-1:0] OFF_PROTO   = HDR_CNT_W'(9);
   localparam logic [HDR_CNT_W-1:0] OFF_SRC     = HDR_CNT_W'(12);
   localparam logic [HDR_CNT_W-1:0] OFF_DST     = HDR_CNT_W'(16);

   localparam byte_t IP_PROTO_UDP = 8'd17;

   // 30 words of 16 bits at most, so 21 bits cannot overflow
   localparam int CSUM_ACC_W = 21;

   typedef enum logic [1:0] {
      ST_HEADER,
      ST_PAYLOAD,
      ST_PAD,
      ST_DROP
   } ip_state_t;

   // Fold the end-around carries back in twice; two passes always suffice for 21 bits
   function automatic logic [15:0] csum_fold(input logic [CSUM_ACC_W-1:0] sum);
      logic [16:0] f1;
      f1 = {1'b0, sum[15:0]} + {12'd0, sum[CSUM_ACC_W-1:16]};
      return f1[15:0] + {15'd0, f1[16]};
   endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Internet checksum accumulator: pairs bytes into big-endian words and sums them.
// is_ok looks ahead by one byte: it reports whether the sum, including the word
// completed by the byte currently on data_in, folds to all ones.
module ip_csum_acc
   import ipv4_parser_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] data_in,
   output logic       is_ok
);

   logic [CSUM_ACC_W-1:0] acc_reg;
   logic [7:0]            hi_reg;
   logic                  odd_reg;
   logic [CSUM_ACC_W-1:0] acc_word;

   // Sum as it will be once the current byte closes a word
   always_comb begin
      acc_word = acc_reg + {{(CSUM_ACC_W-16){1'b0}}, hi_reg, data_in};
      is_ok    = odd_reg && (csum_fold(acc_word) == 16'hFFFF);
   end

   // Byte pairing and accumulation; clear wins over add so a closing byte restarts cleanly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         hi_reg  <= '0;
         odd_reg <= 1'b0;
      end else if (clear) begin
         acc_reg <= '0;
         hi_reg  <= '0;
         odd_reg <= 1'b0;
      end else if (add) begin
         if (odd_reg) begin
            acc_reg <= acc_word;
            odd_reg <= 1'b0;
         end else begin
            hi_reg  <= data_in;
            odd_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ipv4_parser.sv
// IPv4 header strip/validate stage: forwards only the IP payload bytes of
// accepted datagrams and exposes source address and payload length.
module ipv4_parser
   import ipv4_parser_pkg::*;
#(
   parameter byte_t    PROTOCOL     = IP_PROTO_UDP,
   parameter ip_addr_t LOCAL_IP     = 32'hC0A8_010A,
   parameter bit       ACCEPT_BCAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  eth_data_in,
   input  logic        eth_byte_valid,
   input  logic        eth_eof,
   input  logic        eth_err,
   output logic [7:0]  ip_data_out,
   output logic        ip_byte_valid,
   output logic        ip_eof,
   output logic        ip_err,
   output logic [31:0] ip_src_addr,
   output logic [15:0] ip_payload_len
);

   ip_state_t             state_reg, state_next;
   logic [HDR_CNT_W-1:0]  hdr_cnt_reg, hdr_cnt_next;
   logic [3:0]            ihl_reg, ihl_next;
   logic [15:0]           totlen_reg, totlen_next;
   logic [7:0]            proto_reg, proto_next;
   logic                  frag_bad_reg, frag_bad_next;
   logic [31:0]           src_reg, src_next;
   logic [31:0]           dst_reg, dst_next;
   logic [15:0]           pay_cnt_reg, pay_cnt_next;

   logic [7:0]            data_next;
   logic                  valid_next, eof_next, err_next;
   logic [31:0]           src_addr_next;
   logic [15:0]           payload_len_next;

   logic                  csum_clear, csum_add, csum_ok;
   logic [HDR_CNT_W-1:0]  hdr_len, hdr_last;
   logic [31:0]           dst_final;
   logic [15:0]           payload_len_calc;
   logic                  dst_ok, hdr_accept;

   assign csum_add = eth_byte_valid && (state_reg == ST_HEADER);

   ip_csum_acc u_csum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (csum_clear),
      .add     (csum_add),
      .data_in (eth_data_in),
      .is_ok   (csum_ok)
   );

   // Header verdict, evaluated on the last header byte (the dst may still be completing)
   always_comb begin
      hdr_len          = {ihl_reg, 2'b00};
      hdr_last         = hdr_len - HDR_CNT_W'(1);
      dst_final        = (hdr_cnt_reg == OFF_DST + HDR_CNT_W'(3)) ?
                         {dst_reg[23:0], eth_data_in} : dst_reg;
      payload_len_calc = totlen_reg - {10'd0, hdr_len};
      dst_ok           = (dst_final == LOCAL_IP) ||
                         (ACCEPT_BCAST && (dst_final == 32'hFFFF_FFFF));
      hdr_accept       = csum_ok && (proto_reg == PROTOCOL) && dst_ok &&
                         !frag_bad_reg && (totlen_reg >= {10'd0, hdr_len});
   end

   // Next-state, field capture and output decode
   always_comb begin
      state_next       = state_reg;
      hdr_cnt_next     = hdr_cnt_reg;
      ihl_next         = ihl_reg;
      totlen_next      = totlen_reg;
      proto_next       = proto_reg;
      frag_bad_next    = frag_bad_reg;
      src_next         = src_reg;
      dst_next         = dst_reg;
      pay_cnt_next     = pay_cnt_reg;
      data_next        = ip_data_out;
      valid_next       = 1'b0;
      eof_next         = 1'b0;
      err_next         = 1'b0;
      src_addr_next    = ip_src_addr;
      payload_len_next = ip_payload_len;
      csum_clear       = 1'b0;

      if (eth_byte_valid) begin
         case (state_reg)
            ST_HEADER: begin
               if (eth_eof || eth_err) begin
                  // Frame ended inside the header: reject, stay ready for a new header
                  err_next     = 1'b1;
                  hdr_cnt_next = '0;
                  csum_clear   = 1'b1;
               end else begin
                  hdr_cnt_next = hdr_cnt_reg + HDR_CNT_W'(1);
                  if (hdr_cnt_reg == OFF_TOTLEN)                  totlen_next[15:8] = eth_data_in;
                  if (hdr_cnt_reg == OFF_TOTLEN + HDR_CNT_W'(1))  totlen_next[7:0]  = eth_data_in;
                  if (hdr_cnt_reg == OFF_PROTO)                   proto_next        = eth_data_in;
                  if (hdr_cnt_reg == OFF_FLAGS)
                     frag_bad_next = eth_data_in[5] | (|eth_data_in[4:0]);
                  if (hdr_cnt_reg == OFF_FLAGS + HDR_CNT_W'(1))
                     frag_bad_next = frag_bad_reg | (|eth_data_in);
                  if (hdr_cnt_reg >= OFF_SRC && hdr_cnt_reg < OFF_DST)
                     src_next = {src_reg[23:0], eth_data_in};
                  if (hdr_cnt_reg >= OFF_DST && hdr_cnt_reg < OFF_DST + HDR_CNT_W'(4))
                     dst_next = {dst_reg[23:0], eth_data_in};

                  if (hdr_cnt_reg == OFF_VER_IHL) begin
                     ihl_next = eth_data_in[3:0];
                     if (eth_data_in[7:4] != 4'd4 ||
                         {eth_data_in[3:0], 2'b00} < IPV4_MIN_HDR_LEN) begin
                        err_next     = 1'b1;
                        hdr_cnt_next = '0;
                        csum_clear   = 1'b1;
                        state_next   = ST_DROP;
                     end
                  end else if (hdr_cnt_reg == hdr_last) begin
                     hdr_cnt_next = '0;
                     csum_clear   = 1'b1;
                     if (hdr_accept) begin
                        src_addr_next    = src_reg;
                        payload_len_next = payload_len_calc;
                        pay_cnt_next     = payload_len_calc;
                        state_next       = (payload_len_calc == 16'd0) ? ST_PAD : ST_PAYLOAD;
                     end else begin
                        err_next   = 1'b1;
                        state_next = ST_DROP;
                     end
                  end
               end
            end

            ST_PAYLOAD: begin
               if (eth_err) begin
                  eof_next   = 1'b1;
                  err_next   = 1'b1;
                  state_next = ST_HEADER;
               end else begin
                  data_next    = eth_data_in;
                  valid_next   = 1'b1;
                  pay_cnt_next = pay_cnt_reg - 16'd1;
                  if (eth_eof) begin
                     // Ending before the count runs out means a truncated datagram
                     eof_next   = 1'b1;
                     err_next   = (pay_cnt_reg != 16'd1);
                     state_next = ST_HEADER;
                  end else if (pay_cnt_reg == 16'd1) begin
                     state_next = ST_PAD;
                  end
               end
            end

            ST_PAD: begin
               if (eth_eof || eth_err) begin
                  eof_next   = 1'b1;
                  err_next   = eth_err;
                  state_next = ST_HEADER;
               end
            end

            default: begin
               if (eth_eof || eth_err) state_next = ST_HEADER;
            end
         endcase
      end
   end

   // State, captured fields and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_HEADER;
         hdr_cnt_reg    <= '0;
         ihl_reg        <= '0;
         totlen_reg     <= '0;
         proto_reg      <= '0;
         frag_bad_reg   <= 1'b0;
         src_reg        <= '0;
         dst_reg        <= '0;
         pay_cnt_reg    <= '0;
         ip_data_out    <= '0;
         ip_byte_valid  <= 1'b0;
         ip_eof         <= 1'b0;
         ip_err         <= 1'b0;
         ip_src_addr    <= '0;
         ip_payload_len <= '0;
      end else begin
         state_reg      <= state_next;
         hdr_cnt_reg    <= hdr_cnt_next;
         ihl_reg        <= ihl_next;
         totlen_reg     <= totlen_next;
         proto_reg      <= proto_next;
         frag_bad_reg   <= frag_bad_next;
         src_reg        <= src_next;
         dst_reg        <= dst_next;
         pay_cnt_reg    <= pay_cnt_next;
         ip_data_out    <= data_next;
         ip_byte_valid  <= valid_next;
         ip_eof         <= eof_next;
         ip_err         <= err_next;
         ip_src_addr    <= src_addr_next;
         ip_payload_len <= payload_len_next;
      end
   end

endmodule

// File: tb/tb_ipv4_parser.sv
// Self-checking bench for ipv4_parser: directed scenarios plus random frames,
// every output cycle compared against a frame-level reference model.
module tb_ipv4_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  eth_data_in = '0;
   logic        eth_byte_valid = 1'b0;
   logic        eth_eof = 1'b0;
   logic        eth_err = 1'b0;
   logic [7:0]  ip_data_out;
   logic        ip_byte_valid;
   logic        ip_eof;
   logic        ip_err;
   logic [31:0] ip_src_addr;
   logic [15:0] ip_payload_len;

   int n_assert = 0;
   int n_fail   = 0;

   // Expected values for the outputs currently visible
   logic        exp_v = 1'b0, exp_e = 1'b0, exp_r = 1'b0;
   logic [7:0]  exp_d = '0;
   logic [31:0] exp_src = '0;
   logic [15:0] exp_len = '0;

   logic [7:0]  frame_q[$];

   ipv4_parser dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .eth_data_in    (eth_data_in),
      .eth_byte_valid (eth_byte_valid),
      .eth_eof        (eth_eof),
      .eth_err        (eth_err),
      .ip_data_out    (ip_data_out),
      .ip_byte_valid  (ip_byte_valid),
      .ip_eof         (ip_eof),
      .ip_err         (ip_err),
      .ip_src_addr    (ip_src_addr),
      .ip_payload_len (ip_payload_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      chk("ip_byte_valid", 32'(ip_byte_valid), 32'(exp_v));
      chk("ip_eof", 32'(ip_eof), 32'(exp_e));
      chk("ip_err", 32'(ip_err), 32'(exp_r));
      if (exp_v) chk("ip_data_out", 32'(ip_data_out), 32'(exp_d));
      chk("ip_src_addr", ip_src_addr, exp_src);
      chk("ip_payload_len", 32'(ip_payload_len), 32'(exp_len));
   endtask

   // One input cycle: check what the previous cycle produced, then drive and set expectations
   task automatic step(input logic v, input logic [7:0] d, input logic eof, input logic er,
                       input logic xv, input logic xe, input logic xr, input logic [7:0] xd,
                       input logic upd, input logic [31:0] usrc, input logic [15:0] ulen);
      @(negedge clk);
      check_outputs();
      eth_byte_valid = v;
      eth_data_in    = d;
      eth_eof        = eof;
      eth_err        = er;
      exp_v = xv; exp_e = xe; exp_r = xr; exp_d = xd;
      if (upd) begin
         exp_src = usrc;
         exp_len = ulen;
      end
   endtask

   task automatic idle();
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 16'h0);
   endtask

   // Plain one's-complement sum over the first nbytes of frame_q
   function automatic logic [15:0] ref_sum(input int nbytes);
      int s;
      s = 0;
      for (int k = 0; k + 1 < nbytes; k += 2) s += int'({frame_q[k], frame_q[k+1]});
      while (s > 65535) s = (s & 65535) + (s >>> 16);
      return 16'(s);
   endfunction

   task automatic build_frame(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] totlen,
                              input logic [7:0] proto, input logic [31:0] dst,
                              input logic [7:0] fl6, input logic [7:0] fl7,
                              input int body_len, input bit bad_csum);
      int          hsz;
      logic [31:0] src;
      logic [15:0] cs;
      hsz = (ihl >= 4'd5) ? int'(ihl) * 4 : 20;
      src = $urandom;
      frame_q.delete();
      frame_q.push_back({ver, ihl});
      frame_q.push_back(8'h00);
      frame_q.push_back(totlen[15:8]);
      frame_q.push_back(totlen[7:0]);
      frame_q.push_back(8'($urandom));
      frame_q.push_back(8'($urandom));
      frame_q.push_back(fl6);
      frame_q.push_back(fl7);
      frame_q.push_back(8'd64);
      frame_q.push_back(proto);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      for (int k = 3; k >= 0; k--) frame_q.push_back(src[k*8 +: 8]);
      for (int k = 3; k >= 0; k--) frame_q.push_back(dst[k*8 +: 8]);
      while (frame_q.size() < hsz) frame_q.push_back(8'($urandom));
      cs = ~ref_sum(hsz);
      frame_q[10] = cs[15:8];
      frame_q[11] = cs[7:0];
      if (bad_csum) frame_q[11] = frame_q[11] ^ 8'h01;
      for (int k = 0; k < body_len; k++) frame_q.push_back(8'($urandom));
   endtask

   // Reference model over the whole frame, then drive it (optionally stopping early)
   task automatic send_frame(input int stop_after, input bit err_last, input bit gaps);
      int          n, last, hlen, acc_at, plen;
      logic [3:0]  ver, ihl;
      logic [31:0] dst, src;
      logic [15:0] tl;
      bit          ok;
      logic        xv[0:255], xe[0:255], xr[0:255];
      n      = frame_q.size();
      last   = n - 1;
      ver    = frame_q[0][7:4];
      ihl    = frame_q[0][3:0];
      hlen   = int'(ihl) * 4;
      acc_at = -1;
      plen   = 0;
      src    = '0;
      for (int i = 0; i < 256; i++) begin xv[i] = 1'b0; xe[i] = 1'b0; xr[i] = 1'b0; end
      if (ver != 4'd4 || ihl < 4'd5) begin
         xr[0] = 1'b1;
      end else if (last <= hlen - 1) begin
         xr[last] = 1'b1;
      end else begin
         dst = {frame_q[16], frame_q[17], frame_q[18], frame_q[19]};
         tl  = {frame_q[2], frame_q[3]};
         ok  = (ref_sum(hlen) == 16'hFFFF) && (frame_q[9] == 8'd17) &&
               (dst == 32'hC0A8_010A || dst == 32'hFFFF_FFFF) &&
               (frame_q[6][5] == 1'b0) && ({frame_q[6][4:0], frame_q[7]} == 13'd0) &&
               (int'(tl) >= hlen);
         if (!ok) begin
            xr[hlen-1] = 1'b1;
         end else begin
            acc_at = hlen - 1;
            plen   = int'(tl) - hlen;
            src    = {frame_q[12], frame_q[13], frame_q[14], frame_q[15]};
            for (int i = hlen; i <= last; i++) begin
               if (i == last && err_last) begin
                  xe[i] = 1'b1;
                  xr[i] = 1'b1;
               end else begin
                  if (i - hlen < plen) xv[i] = 1'b1;
                  if (i == last) begin
                     xe[i] = 1'b1;
                     if (i - hlen < plen - 1) xr[i] = 1'b1;
                  end
               end
            end
         end
      end
      for (int i = 0; i < n && i < stop_after; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle();
         step(1'b1, frame_q[i], i == last, err_last && i == last,
              xv[i], xe[i], xr[i], frame_q[i], i == acc_at, src, 16'(plen));
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_outputs();
      chk("rst_data", 32'(ip_data_out), 32'h0);
      rst_n = 1'b1;

      // 1: valid UDP, no padding, 12 payload bytes
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h40, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      // 2: padded to 46 bytes, 8 payload bytes
      build_frame(4'd4, 4'd5, 16'h001C, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 26, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      // 3: corrupted checksum, then a good frame
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b1);
      send_frame(1000, 1'b0, 1'b0);
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hFFFF_FFFF, 8'h00, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      // 4: options present, TCP rejected then UDP accepted
      build_frame(4'd4, 4'd6, 16'h0024, 8'd6, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      build_frame(4'd4, 4'd6, 16'h0024, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      // 5: CRC failure after 5 payload bytes
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 6, 1'b0);
      send_frame(1000, 1'b1, 1'b0);
      // 6: bad version, then reset mid-payload, then a clean frame
      build_frame(4'd6, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b0);
      send_frame(25, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs();
      eth_byte_valid = 1'b0;
      eth_eof = 1'b0;
      eth_err = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_v = 1'b0; exp_e = 1'b0; exp_r = 1'b0; exp_src = '0; exp_len = '0;
      check_outputs();
      chk("rst_mid_data", 32'(ip_data_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      build_frame(4'd4, 4'd5, 16'h0020, 8'd17, 32'hC0A8_010A, 8'h00, 8'h00, 12, 1'b0);
      send_frame(1000, 1'b0, 1'b0);

      // Random frames with idle gaps, bad fields, truncation, padding and CRC errors
      for (int f = 0; f < 150; f++) begin
         logic [3:0]  ver, ihl;
         logic [7:0]  proto, fl6, fl7;
         logic [31:0] dst;
         logic [15:0] totlen;
         int          hlen, plen, body, r;
         ver   = ($urandom_range(0, 14) == 0) ? 4'd6 : 4'd4;
         ihl   = ($urandom_range(0, 19) == 0) ? 4'd3 : 4'(5 + $urandom_range(0, 2));
         proto = ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17;
         r     = $urandom_range(0, 5);
         dst   = (r == 0) ? $urandom : (r == 1) ? 32'hFFFF_FFFF : 32'hC0A8_010A;
         fl6   = 8'h40;
         fl7   = 8'h00;
         r     = $urandom_range(0, 11);
         if (r == 0) fl6 = 8'h20;
         if (r == 1) fl7 = 8'h08;
         hlen  = (ihl >= 4'd5) ? int'(ihl) * 4 : 20;
         plen  = $urandom_range(0, 20);
         totlen = ($urandom_range(0, 11) == 0) ? 16'(hlen - 4) : 16'(hlen + plen);
         r = $urandom_range(0, 5);
         if (r == 0)      body = plen + $urandom_range(1, 10);
         else if (r == 1) body = (plen > 0) ? $urandom_range(0, plen - 1) : 0;
         else             body = plen;
         build_frame(ver, ihl, totlen, proto, dst, fl6, fl7, body, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0) begin
            r = $urandom_range(1, hlen - 1);
            while (frame_q.size() > r) void'(frame_q.pop_back());
         end
         send_frame(1000, $urandom_range(0, 9) == 0, 1'b1);
         if ($urandom_range(0, 1) == 0) idle();
      end

      idle();
      @(negedge clk);
      check_outputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
